// File: rtl/watch_set_controller_pkg.sv
// Shared encodings for the watch mode/field sequencer and the display cursor logic.
// Mode encodings, per-mode field indices, strobe bit positions and cursor codes.
package watch_set_controller_pkg;

   typedef enum logic [1:0] {
      WATCH    = 2'd0,
      SET_TIME = 2'd1,
      SET_DATE = 2'd2,
      MODE_BAD = 2'd3
   } mode_e;

   // SET_TIME field indices
   localparam logic [1:0] HOUR    = 2'd0;
   localparam logic [1:0] MIN     = 2'd1;
   localparam logic [1:0] SET_SEC = 2'd2;

   // SET_DATE field indices
   localparam logic [1:0] YEAR  = 2'd0;
   localparam logic [1:0] MONTH = 2'd1;
   localparam logic [1:0] DAY   = 2'd2;

   localparam logic [1:0] FIELD_LAST = 2'd2;

   // inc_time / inc_date bit positions
   localparam int STB_SEC   = 0;
   localparam int STB_MIN   = 1;
   localparam int STB_HOUR  = 2;
   localparam int STB_DAY   = 3;
   localparam int STB_MONTH = 0;
   localparam int STB_YEAR  = 1;

   localparam logic [2:0] CUS_NONE  = 3'd0;
   localparam logic [2:0] CUS_SEC   = 3'd1;
   localparam logic [2:0] CUS_MIN   = 3'd2;
   localparam logic [2:0] CUS_HOUR  = 3'd3;
   localparam logic [2:0] CUS_DAY   = 3'd4;
   localparam logic [2:0] CUS_MONTH = 3'd5;
   localparam logic [2:0] CUS_YEAR  = 3'd6;

   function automatic logic [2:0] cursor_code(input mode_e m, input logic [1:0] f);
      logic [2:0] code;
      code = CUS_NONE;
      case (m)
         SET_TIME: begin
            case (f)
               HOUR:    code = CUS_HOUR;
               MIN:     code = CUS_MIN;
               SET_SEC: code = CUS_SEC;
               default: code = CUS_NONE;
            endcase
         end
         SET_DATE: begin
            case (f)
               YEAR:    code = CUS_YEAR;
               MONTH:   code = CUS_MONTH;
               DAY:     code = CUS_DAY;
               default: code = CUS_NONE;
            endcase
         end
         default: code = CUS_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/watch_set_controller_set_idle_timer.sv
// Idle-seconds counter for the set modes; only instantiated when SET_TIMEOUT_EN is defined.
// expire flags the tick that would bring the count up to TIMEOUT_SEC.
module set_idle_timer #(
   parameter int TIMEOUT_SEC = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   input  logic clear,
   output logic expire
);

   localparam logic [5:0] TERM = 6'(TIMEOUT_SEC - 1);

   logic [5:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= 6'd0;
      end else if (clear) begin
         count_q <= 6'd0;
      end else if (count_en) begin
         count_q <= count_q + 6'd1;
      end
   end

   assign expire = count_en && (count_q == TERM);

endmodule

// File: rtl/watch_set_controller.sv
// Mode/field sequencer: routes divider pulses or user increments to the time/date counters.
// Optional idle timeout back to WATCH is built only when SET_TIMEOUT_EN is defined.
module watch_set_controller
   import watch_set_controller_pkg::*;
#(
   parameter int TIMEOUT_SEC = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_pedge,
   input  logic       sel_pedge,
   input  logic       inc_pedge,
   input  logic       tick_sec,
   input  logic       carry_min,
   input  logic       carry_hour,
   input  logic       carry_day,
   output logic [1:0] mode,
   output logic [3:0] inc_time,
   output logic [1:0] inc_date,
   output logic [2:0] cursor_pos,
   output logic       cursor_blink
);

   // state    | meaning
   // WATCH    | normal timekeeping, divider pulses forwarded
   // SET_TIME | editing hour / min / sec, time frozen
   // SET_DATE | editing year / month / day, time frozen
   // MODE_BAD | unreachable, falls back to WATCH

   mode_e      state_q, state_d;
   logic [1:0] field_q, field_d;
   logic [3:0] inc_time_d;
   logic [1:0] inc_date_d;
   logic [2:0] cursor_pos_d;
   logic       blink_q, blink_d;
   logic       in_set, sel_acc, inc_acc, timeout;

   assign in_set  = (state_q == SET_TIME) || (state_q == SET_DATE);
   assign sel_acc = in_set && !mode_pedge && sel_pedge;
   assign inc_acc = in_set && !mode_pedge && !sel_pedge && inc_pedge;

`ifdef SET_TIMEOUT_EN
   logic idle_expire;
   logic idle_clear;

   assign idle_clear = mode_pedge || sel_acc || inc_acc || (state_d == WATCH);

   set_idle_timer #(
      .TIMEOUT_SEC (TIMEOUT_SEC)
   ) u_set_idle_timer (
      .clk      (clk),
      .reset    (reset),
      .count_en (in_set && tick_sec),
      .clear    (idle_clear),
      .expire   (idle_expire)
   );

   // A button press in the expiring cycle counts as activity and cancels the timeout.
   assign timeout = idle_expire && !sel_acc && !inc_acc;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_SEC != 0);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= WATCH;
         field_q      <= 2'd0;
         blink_q      <= 1'b0;
         inc_time     <= 4'd0;
         inc_date     <= 2'd0;
         cursor_pos   <= CUS_NONE;
      end else begin
         state_q      <= state_d;
         field_q      <= field_d;
         blink_q      <= blink_d;
         inc_time     <= inc_time_d;
         inc_date     <= inc_date_d;
         cursor_pos   <= cursor_pos_d;
      end
   end

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      case (state_q)
         WATCH: begin
            if (mode_pedge) state_d = SET_TIME;
         end
         SET_TIME: begin
            if (mode_pedge)   state_d = SET_DATE;
            else if (timeout) state_d = WATCH;
         end
         SET_DATE: begin
            if (mode_pedge || timeout) state_d = WATCH;
         end
         default: state_d = WATCH;
      endcase

      if (state_d != state_q) begin
         field_d = 2'd0;
      end else if (sel_acc) begin
         field_d = (field_q >= FIELD_LAST) ? 2'd0 : field_q + 2'd1;
      end
   end

   always_comb begin
      inc_time_d = 4'd0;
      inc_date_d = 2'd0;
      if (state_q == WATCH) begin
         inc_time_d = {carry_day, carry_hour, carry_min, tick_sec};
      end else if (inc_acc) begin
         if (state_q == SET_TIME) begin
            case (field_q)
               HOUR:    inc_time_d[STB_HOUR] = 1'b1;
               MIN:     inc_time_d[STB_MIN]  = 1'b1;
               SET_SEC: inc_time_d[STB_SEC]  = 1'b1;
               default: inc_time_d = 4'd0;
            endcase
         end else begin
            case (field_q)
               YEAR:    inc_date_d[STB_YEAR]  = 1'b1;
               MONTH:   inc_date_d[STB_MONTH] = 1'b1;
               DAY:     inc_time_d[STB_DAY]   = 1'b1;
               default: inc_date_d = 2'd0;
            endcase
         end
      end

      cursor_pos_d = cursor_code(state_d, field_d);

      if (!((state_d == SET_TIME) || (state_d == SET_DATE))) begin
         blink_d = 1'b0;
      end else if ((state_d != state_q) || sel_acc || inc_acc) begin
         blink_d = 1'b1;
      end else if (tick_sec) begin
         blink_d = !blink_q;
      end else begin
         blink_d = blink_q;
      end
   end

   assign mode         = state_q;
   assign cursor_blink = blink_q;

endmodule

// File: tb/tb_watch_set_controller.sv
// Directed self-checking bench for watch_set_controller (TIMEOUT_SEC = 3).
// Timeout steps follow SET_TIMEOUT_EN so the bench matches whichever build it is compiled with.
module tb_watch_set_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode_pedge, sel_pedge, inc_pedge, tick_sec;
   logic       carry_min, carry_hour, carry_day;
   logic [1:0] mode;
   logic [3:0] inc_time;
   logic [1:0] inc_date;
   logic [2:0] cursor_pos;
   logic       cursor_blink;

   int total = 0;
   int bad   = 0;

   watch_set_controller #(
      .TIMEOUT_SEC (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mode_pedge   (mode_pedge),
      .sel_pedge    (sel_pedge),
      .inc_pedge    (inc_pedge),
      .tick_sec     (tick_sec),
      .carry_min    (carry_min),
      .carry_hour   (carry_hour),
      .carry_day    (carry_day),
      .mode         (mode),
      .inc_time     (inc_time),
      .inc_date     (inc_date),
      .cursor_pos   (cursor_pos),
      .cursor_blink (cursor_blink)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_all(input string tag, input int m, input int t, input int d,
                             input int c, input int b);
      chk({tag, ".mode"},   8'(mode),         8'(m));
      chk({tag, ".time"},   8'(inc_time),     8'(t));
      chk({tag, ".date"},   8'(inc_date),     8'(d));
      chk({tag, ".cursor"}, 8'(cursor_pos),   8'(c));
      chk({tag, ".blink"},  8'(cursor_blink), 8'(b));
   endtask

   // One clock: hold the given pulses across a rising edge, then release them.
   task automatic step(input logic m, input logic s, input logic i, input logic t,
                       input logic cm, input logic ch, input logic cd);
      mode_pedge = m;  sel_pedge = s;  inc_pedge = i;  tick_sec = t;
      carry_min  = cm; carry_hour = ch; carry_day = cd;
      @(posedge clk);
      #1;
      mode_pedge = 0;  sel_pedge = 0;  inc_pedge = 0;  tick_sec = 0;
      carry_min  = 0;  carry_hour = 0; carry_day = 0;
   endtask

   initial begin
      reset = 1'b1;
      mode_pedge = 0; sel_pedge = 0; inc_pedge = 0; tick_sec = 0;
      carry_min = 0; carry_hour = 0; carry_day = 0;
      #12;
      expect_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;

      // WATCH: ticks forwarded one cycle later, one cycle wide
      step(0,0,0,1,0,0,0); expect_all("w_tick1", 0, 1, 0, 0, 0);
      step(0,0,0,0,0,0,0); expect_all("w_idle1", 0, 0, 0, 0, 0);
      step(0,0,0,1,0,0,0); expect_all("w_tick2", 0, 1, 0, 0, 0);
      step(0,0,0,1,0,0,0); expect_all("w_tick3", 0, 1, 0, 0, 0);
      step(0,0,0,0,0,0,0); expect_all("w_idle2", 0, 0, 0, 0, 0);
      step(0,0,0,1,1,1,1); expect_all("w_carry", 0, 15, 0, 0, 0);
      step(0,0,1,0,0,0,0); expect_all("w_inc",   0, 0, 0, 0, 0);
      step(0,1,0,0,0,0,0); expect_all("w_sel",   0, 0, 0, 0, 0);

      // SET_TIME: select MIN, two increments with divider pulses suppressed
      step(1,0,0,0,0,0,0); expect_all("st_enter", 1, 0, 0, 3, 1);
      step(0,1,0,0,0,0,0); expect_all("st_sel",   1, 0, 0, 2, 1);
      step(0,0,1,1,1,0,0); expect_all("st_inc1",  1, 2, 0, 2, 1);
      step(0,0,1,1,1,0,0); expect_all("st_inc2",  1, 2, 0, 2, 1);
      step(0,0,0,1,0,0,0); expect_all("st_tick",  1, 0, 0, 2, 0);
      step(0,0,0,0,1,1,1); expect_all("st_carry", 1, 0, 0, 2, 0);
      step(0,0,0,1,0,0,0); expect_all("st_tick2", 1, 0, 0, 2, 1);

      // mode beats inc; SET_DATE fields YEAR, MONTH, DAY and wrap
      step(1,0,1,0,0,0,0); expect_all("mode_inc", 2, 0, 0, 6, 1);
      step(0,0,1,0,0,0,0); expect_all("sd_year",  2, 0, 2, 6, 1);
      step(0,0,0,1,0,0,0); expect_all("sd_tick",  2, 0, 0, 6, 0);
      step(0,1,0,0,0,0,0); expect_all("sd_sel1",  2, 0, 0, 5, 1);
      step(0,0,1,0,0,0,0); expect_all("sd_month", 2, 0, 1, 5, 1);
      step(0,1,0,0,0,0,0); expect_all("sd_sel2",  2, 0, 0, 4, 1);
      step(0,0,1,1,0,0,0); expect_all("sd_day",   2, 8, 0, 4, 1);
      step(0,1,0,0,0,0,0); expect_all("sd_wrap",  2, 0, 0, 6, 1);
      step(0,1,1,0,0,0,0); expect_all("sel_inc",  2, 0, 0, 5, 1);

      // back to WATCH; tick coincident with leaving WATCH still forwarded
      step(1,0,0,0,0,0,0); expect_all("to_watch", 0, 0, 0, 0, 0);
      step(1,0,0,1,0,0,0); expect_all("leave_w",  1, 1, 0, 3, 1);
      step(1,0,0,0,0,0,0); expect_all("to_date",  2, 0, 0, 6, 1);
      step(0,1,0,0,0,0,0); expect_all("d_sel1",   2, 0, 0, 5, 1);
      step(0,1,0,0,0,0,0); expect_all("d_sel2",   2, 0, 0, 4, 1);
      step(0,0,1,0,0,0,0); expect_all("d_strobe", 2, 8, 0, 4, 1);

      // asynchronous reset while the DAY strobe is visible
      reset = 1'b1;
      #1;
      expect_all("mid_reset", 0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      step(0,0,0,1,0,0,0); expect_all("post_rst", 0, 1, 0, 0, 0);

      // idle behaviour in SET_TIME
      step(1,0,0,0,0,0,0); expect_all("to_enter", 1, 0, 0, 3, 1);
      step(0,0,0,1,0,0,0); expect_all("to_t1",    1, 0, 0, 3, 0);
      step(0,0,0,1,0,0,0); expect_all("to_t2",    1, 0, 0, 3, 1);
`ifdef SET_TIMEOUT_EN
      step(0,0,0,1,0,0,0); expect_all("to_t3",    0, 0, 0, 0, 0);
      step(1,0,0,0,0,0,0); expect_all("to_re",    1, 0, 0, 3, 1);
      step(0,0,0,1,0,0,0); expect_all("to_r1",    1, 0, 0, 3, 0);
      step(0,0,0,1,0,0,0); expect_all("to_r2",    1, 0, 0, 3, 1);
      step(0,0,1,0,0,0,0); expect_all("to_inc",   1, 4, 0, 3, 1);
      step(0,0,0,1,0,0,0); expect_all("to_r3",    1, 0, 0, 3, 0);
      step(0,0,0,1,0,0,0); expect_all("to_r4",    1, 0, 0, 3, 1);
      step(0,0,0,1,0,0,0); expect_all("to_r5",    0, 0, 0, 0, 0);
      step(1,0,0,0,0,0,0); expect_all("to_m1",    1, 0, 0, 3, 1);
      step(0,0,0,1,0,0,0); expect_all("to_m2",    1, 0, 0, 3, 0);
      step(0,0,0,1,0,0,0); expect_all("to_m3",    1, 0, 0, 3, 1);
      step(1,0,0,1,0,0,0); expect_all("to_mwin",  2, 0, 0, 6, 1);
      step(0,0,0,1,0,0,0); expect_all("to_d1",    2, 0, 0, 6, 0);
      step(0,0,0,1,0,0,0); expect_all("to_d2",    2, 0, 0, 6, 1);
      step(0,0,0,1,0,0,0); expect_all("to_d3",    0, 0, 0, 0, 0);
`else
      step(0,0,0,1,0,0,0); expect_all("nto_t3",   1, 0, 0, 3, 0);
      step(0,0,0,1,0,0,0); expect_all("nto_t4",   1, 0, 0, 3, 1);
      step(0,0,0,1,0,0,0); expect_all("nto_t5",   1, 0, 0, 3, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
